hamming_secded_codec: RTL and testbench
=======================================

# hamming_secded_codec

Parametrised SECDED Hamming codec: encodes DATA_W-bit words into extended-Hamming codewords, or decodes codewords with single-error correction and double-error detection. The mode is selected per transaction. It is a 2-stage pipelined stream block with valid/ready handshakes on both sides and saturating error counters. It sits between datapath producers and storage or link interfaces.

## Interface
- DATA_W, 16: data width, legal 4..64.
- CNT_W, 16: width of each error counter.
- Derived, not overridable:
  - PAR_W = smallest r with 2^r >= DATA_W+r+1 (5 for 16).
  - N = DATA_W+PAR_W.
  - CODE_W = N+1 (22 for 16).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_mode  in  1  0 = encode, 1 = decode.
- in_data  in  CODE_W  encode: bits [DATA_W-1:0] used, upper bits ignored; decode: full codeword.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_mode  out  1  mode of the current result.
- out_data  out  CODE_W  encode: codeword; decode: corrected data, zero-extended.
- out_syndrome  out  PAR_W  decode syndrome; 0 in encode mode.
- out_corr  out  1  single error corrected (decode only).
- out_uncorr  out  1  uncorrectable error (decode only).
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected results.
- uncorr_cnt  out  CNT_W  count of uncorrectable results.

## Operation
- Codeword layout:
  - Position p = 1..N maps to bit index p-1.
  - Check bits sit at positions 2^m, m = 0..PAR_W-1.
  - Data bits fill the remaining positions in ascending order; data bit 0 is at position 3.
  - Index CODE_W-1 holds the overall bit: even parity over bits [N-1:0].
- Check bit m = XOR of the data bits whose position has bit m set.
- Encode: scatter the data with check bits zero, compute the check bits, insert them, then append the overall bit.
- Decode:
  - s = XOR of all positions p whose bit is 1, PAR_W bits wide.
  - q = XOR of all CODE_W bits.
- Decode outcomes:
  - s=0, q=0: clean. corr=0, uncorr=0.
  - q=1, s=0: overall bit in error. Data unchanged, corr=1.
  - q=1, 1<=s<=N: flip position s, then extract data. corr=1.
  - q=1, s>N: uncorr=1. Data is extracted uncorrected.
  - s!=0, q=0: double error. uncorr=1, data extracted uncorrected.
- out_syndrome = s in all decode cases.
- Counters:
  - Increment on the output handshake when out_corr (resp. out_uncorr) is set.
  - Saturate at all-ones.
  - cnt_clr has priority over increment: simultaneous clear and event gives 0.

## Timing
- Two register stages:
  - S1 registers the placed vector, mode, s and q.
  - S2 registers out_data and the flags.
- Both stages advance on en = !out_valid || out_ready.
- in_ready = en. This is a combinational path from out_ready and out_valid; there is no other combinational input-to-output path.
- Latency: accepted input appears on out_valid 2 cycles later with no stall. Throughput is 1 per cycle.
- Stall with out_ready=0 and out_valid=1:
  - All stages hold and in_ready=0.
  - Output fields stay stable while out_valid=1 && !out_ready.
- A pipeline bubble (S1 empty) propagates; out_valid drops when S2 advances an empty S1.
- Order is preserved; there is no loss and no duplication.
- Reset:
  - in_ready=1 after the first post-reset cycle (combinational from out_valid=0).
  - out_valid=0, out_data=0, out_mode=0, out_syndrome=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0.
  - Reset mid-operation discards all in-flight transactions.

## Structure
- Package hamming_pkg:
  - Function calc_par_w(data_w).
  - Function is_pow2(p).
  - Mode constants MODE_ENC=1'b0, MODE_DEC=1'b1.
- One sub-module, hamming_syndrome: combinational, parameter DATA_W, input CODE_W vector, output PAR_W check vector plus overall parity.
  - Instantiated once in S1 and shared.
  - Encode feeds the scattered data with check bits zero; decode feeds the received codeword.

## Test plan
- Encode 16'h0001, DATA_W=16 -> out_data 22'h200007, flags 0, out_valid exactly 2 cycles after acceptance.
- Decode 22'h200017 (position 5 flipped) -> out_data 16'h0001, out_syndrome 5, out_corr=1, corr_cnt=1.
- Decode 22'h000007 (overall bit flipped) -> out_data 16'h0001, out_syndrome 0, out_corr=1.
- Decode 22'h200013 (positions 3 and 5 flipped) -> out_uncorr=1, out_syndrome 6, out_data 16'h0002, uncorr_cnt=1.
- Backpressure: 3 back-to-back encodes with out_ready=0 for 5 cycles -> only 2 accepted, in_ready=0, outputs stable; on release all 3 are delivered in order.
- CNT_W=2: 5 corrected decodes -> corr_cnt=3. Then cnt_clr asserted in the same cycle as a corrected handshake -> corr_cnt=0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and elaboration-time helpers for the SECDED codec:
// parity-width sizing and the position map of data bits inside a codeword.
package hamming_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r = r + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Codeword position (1-based) of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p <= 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_codec_if.sv
// Stream interface of the codec: input request channel and output result channel.
interface hamming_secded_codec_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 16
);
  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [CODE_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_corr;
  logic              out_uncorr;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_syndrome, out_corr, out_uncorr
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_syndrome, out_corr, out_uncorr
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational check-vector generator: XOR of the positions of all set bits
// in [N-1:0], plus the parity of the whole vector.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int N      = DATA_W + PAR_W,
  localparam int CODE_W = N + 1
) (
  input  logic [CODE_W-1:0] vec_i,
  output logic [PAR_W-1:0]  chk_o,
  output logic              par_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    chk_o = '0;
    for (int p = 1; p <= N; p++) begin
      if (vec_i[p-1]) chk_o = chk_o ^ PAR_W'(p);
    end
    par_o = ^vec_i;
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage SECDED Hamming encode/decode pipeline with valid/ready on both
// sides and saturating corrected/uncorrectable event counters.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_secded_codec_if.slave  bus,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt
);
  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int N      = DATA_W + PAR_W;
  localparam int CODE_W = N + 1;

  logic              en;
  logic              out_valid_q;
  logic [N-1:0]      scat;
  logic [N-1:0]      enc_vec;
  logic [N-1:0]      fixed_vec;
  logic [DATA_W-1:0] dec_data;
  logic [CODE_W-1:0] syn_in;
  logic [PAR_W-1:0]  syn_chk;
  logic              syn_par;

  // Whole pipe moves together; a stalled output freezes both stages.
  assign en          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data_map
    localparam int P = data_pos(i);
    assign scat[P-1]   = bus.in_data[i];
    assign dec_data[i] = fixed_vec[P-1];
  end

  for (genvar m = 0; m < PAR_W; m++) begin : g_chk_zero
    assign scat[(1 << m) - 1] = 1'b0;
  end

  // Encode computes check bits over the scattered data; decode computes s and q.
  assign syn_in = (bus.in_mode == MODE_DEC) ? bus.in_data : {1'b0, scat};

  hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .vec_i (syn_in),
    .chk_o (syn_chk),
    .par_o (syn_par)
  );

  always_comb begin
    enc_vec = scat;
    for (int m = 0; m < PAR_W; m++) enc_vec[(1 << m) - 1] = syn_chk[m];
  end

  // Stage 1: placed vector, mode, syndrome and overall parity.
  logic              s1_valid_q;
  logic              s1_mode_q;
  logic              s1_par_q;
  logic [N-1:0]      s1_vec_q;
  logic [N-1:0]      s1_vec_d;
  logic [PAR_W-1:0]  s1_syn_q;

  assign s1_vec_d = (bus.in_mode == MODE_DEC) ? bus.in_data[N-1:0] : enc_vec;

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so outputs read back as zero after reset.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_ENC;
      s1_par_q   <= 1'b0;
      s1_vec_q   <= '0;
      s1_syn_q   <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      s1_valid_q <= bus.in_valid;
      s1_mode_q  <= bus.in_mode;
      s1_par_q   <= syn_par;
      s1_vec_q   <= s1_vec_d;
      s1_syn_q   <= syn_chk;
    end
  end

  // Stage 2 combinational: single-bit repair and outcome classification.
  always_comb begin
    fixed_vec = s1_vec_q;
    for (int p = 1; p <= N; p++) begin
      if (s1_par_q && (s1_syn_q == PAR_W'(p))) fixed_vec[p-1] = ~s1_vec_q[p-1];
    end
  end

  logic [CODE_W-1:0] out_data_d,   out_data_q;
  logic [PAR_W-1:0]  out_syn_d,    out_syn_q;
  logic              out_corr_d,   out_corr_q;
  logic              out_uncorr_d, out_uncorr_q;
  logic              out_mode_q;

  always_comb begin
    out_data_d   = '0;
    out_syn_d    = '0;
    out_corr_d   = 1'b0;
    out_uncorr_d = 1'b0;
    if (s1_mode_q == MODE_DEC) begin
      out_data_d   = CODE_W'(dec_data);
      out_syn_d    = s1_syn_q;
      out_corr_d   = s1_par_q && (s1_syn_q <= PAR_W'(N));
      out_uncorr_d = (s1_par_q && (s1_syn_q > PAR_W'(N))) || (!s1_par_q && (s1_syn_q != '0));
    end else begin
      out_data_d = {^s1_vec_q, s1_vec_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_mode_q   <= MODE_ENC;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else if (en) begin
      out_valid_q  <= s1_valid_q;
      out_mode_q   <= s1_mode_q;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_mode     = out_mode_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_syndrome = out_syn_q;
  assign bus.out_corr     = out_corr_q;
  assign bus.out_uncorr   = out_uncorr_q;

  // Event counters: clear wins over a same-cycle event; both stick at all-ones.
  logic             out_fire;
  logic [CNT_W-1:0] corr_cnt_d,   corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_d, uncorr_cnt_q;

  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (out_corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (out_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Self-checking bench for hamming_secded_codec: directed vectors, backpressure,
// randomized traffic against a positional reference model, reset and counter limits.
`timescale 1ns/1ps
module tb_hamming_secded_codec;
  import hamming_pkg::*;

  localparam int DW = 16;
  localparam int PW = 5;
  localparam int NN = 21;
  localparam int CW = 22;
  localparam int N_RAND = 300;
  localparam int RAND_LIMIT = 4000;

  typedef struct packed {
    logic          mode;
    logic [CW-1:0] data;
    logic [PW-1:0] syn;
    logic          corr;
    logic          uncorr;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cnt_clr, cnt_clr2;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic [1:0]  corr_cnt2, uncorr_cnt2;

  hamming_secded_codec_if #(.DATA_W(DW)) bus ();
  hamming_secded_codec_if #(.DATA_W(DW)) bus2 ();

  hamming_secded_codec #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_codec #(.DATA_W(DW), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .bus(bus2), .cnt_clr(cnt_clr2),
    .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  int total = 0;
  int bad   = 0;
  int exp_corr, exp_uncorr;
  int dpos [DW];

  // Directed vectors: {mode, input, expected data, syndrome, corr, uncorr, counters after}.
  logic          t_mode [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [CW-1:0] t_in   [5] = '{22'h000001, 22'h200017, 22'h000007, 22'h200013, 22'h0080C0};
  logic [CW-1:0] t_out  [5] = '{22'h200007, 22'h000001, 22'h000001, 22'h000002, 22'h000008};
  logic [PW-1:0] t_syn  [5] = '{5'd0, 5'd5, 5'd0, 5'd6, 5'd31};
  logic          t_corr [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic          t_unc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int            t_cc   [5] = '{0, 1, 2, 2, 2};
  int            t_uc   [5] = '{0, 0, 0, 1, 2};

  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    logic b;
    cw = '0;
    for (int i = 0; i < DW; i++) cw[dpos[i]-1] = d[i];
    for (int m = 0; m < PW; m++) begin
      b = 1'b0;
      for (int i = 0; i < DW; i++) if (((dpos[i] >> m) & 1) != 0) b = b ^ d[i];
      cw[(1 << m) - 1] = b;
    end
    cw[CW-1] = ^cw[NN-1:0];
    return cw;
  endfunction

  function automatic logic [DW-1:0] m_extract(input logic [CW-1:0] cw);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW; i++) d[i] = cw[dpos[i]-1];
    return d;
  endfunction

  function automatic res_t m_decode(input logic [CW-1:0] cw);
    res_t r;
    int s;
    logic q;
    logic [CW-1:0] fx;
    s = 0;
    for (int p = 1; p <= NN; p++) if (cw[p-1]) s = s ^ p;
    q = ^cw;
    fx = cw;
    r.mode = 1'b1;
    r.syn = PW'(s);
    r.corr = 1'b0;
    r.uncorr = 1'b0;
    if (q && s == 0) r.corr = 1'b1;
    else if (q && s <= NN) begin
      fx[s-1] = ~fx[s-1];
      r.corr = 1'b1;
    end else if (s != 0) r.uncorr = 1'b1;
    r.data = CW'(m_extract(fx));
    return r;
  endfunction

  function automatic res_t m_expect(input logic mode, input logic [CW-1:0] din);
    res_t r;
    if (mode == MODE_DEC) r = m_decode(din);
    else r = '{mode: 1'b0, data: m_encode(din[DW-1:0]), syn: '0, corr: 1'b0, uncorr: 1'b0};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_mode = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_mode = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    cnt_clr = 1'b0; cnt_clr2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_mode !== 1'b0) begin bad++; $display("FAIL reset_out_mode: got %b want 0", bus.out_mode); end
    total++; if (bus.out_syndrome !== '0) begin bad++; $display("FAIL reset_syndrome: got %h want 0", bus.out_syndrome); end
    total++; if ({bus.out_corr, bus.out_uncorr} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {bus.out_corr, bus.out_uncorr}); end
    total++; if ({corr_cnt, uncorr_cnt} !== 32'h0) begin bad++; $display("FAIL reset_counters: got %h/%h want 0/0", corr_cnt, uncorr_cnt); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++; if ({corr_cnt2, uncorr_cnt2} !== 4'h0) begin bad++; $display("FAIL reset_counters_c2: got %h/%h want 0/0", corr_cnt2, uncorr_cnt2); end
  endtask

  task automatic test_directed();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_mode = t_mode[k]; bus.in_data = t_in[k]; bus.out_ready = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready: got %b want 1", k, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid: got %b want 0", k, bus.out_valid); end
      @(negedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency: got out_valid %b want 1", k, bus.out_valid); end
      total++; if (bus.out_data !== t_out[k]) begin bad++; $display("FAIL dir%0d_data: got %h want %h", k, bus.out_data, t_out[k]); end
      total++; if (bus.out_mode !== t_mode[k]) begin bad++; $display("FAIL dir%0d_mode: got %b want %b", k, bus.out_mode, t_mode[k]); end
      total++; if (bus.out_syndrome !== t_syn[k]) begin bad++; $display("FAIL dir%0d_syndrome: got %0d want %0d", k, bus.out_syndrome, t_syn[k]); end
      total++; if ({bus.out_corr, bus.out_uncorr} !== {t_corr[k], t_unc[k]}) begin
        bad++; $display("FAIL dir%0d_flags: got corr/uncorr %b%b want %b%b", k, bus.out_corr, bus.out_uncorr, t_corr[k], t_unc[k]);
      end
      @(negedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_bubble: got out_valid %b want 0", k, bus.out_valid); end
      total++; if (corr_cnt !== 16'(t_cc[k])) begin bad++; $display("FAIL dir%0d_corr_cnt: got %0d want %0d", k, corr_cnt, t_cc[k]); end
      total++; if (uncorr_cnt !== 16'(t_uc[k])) begin bad++; $display("FAIL dir%0d_uncorr_cnt: got %0d want %0d", k, uncorr_cnt, t_uc[k]); end
    end
    exp_corr = 2;
    exp_uncorr = 2;
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] items [3];
    res_t saved, cur;
    int idx, acc, got;
    for (int i = 0; i < 3; i++) items[i] = CW'($urandom);
    idx = 0; acc = 0; got = 0;
    saved = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = (idx < 3);
      bus.in_mode = MODE_ENC;
      if (idx < 3) bus.in_data = items[idx];
      #1;
      cur = {bus.out_mode, bus.out_data, bus.out_syndrome, bus.out_corr, bus.out_uncorr};
      if (bus.in_valid && bus.in_ready) begin acc++; idx++; end
      if (c == 2) begin
        saved = cur;
        total++; if (cur !== m_expect(MODE_ENC, items[0])) begin bad++; $display("FAIL bp_head: got %h want %h", cur, m_expect(MODE_ENC, items[0])); end
      end else if (c > 2) begin
        total++; if ({bus.out_valid, cur} !== {1'b1, saved}) begin bad++; $display("FAIL bp_stable: got %b/%h want 1/%h", bus.out_valid, cur, saved); end
      end
    end
    total++; if (acc !== 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = (idx < 3);
      if (idx < 3) bus.in_data = items[idx];
      #1;
      cur = {bus.out_mode, bus.out_data, bus.out_syndrome, bus.out_corr, bus.out_uncorr};
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        total++; if (cur !== m_expect(MODE_ENC, items[got])) begin bad++; $display("FAIL bp_order%0d: got %h want %h", got, cur, m_expect(MODE_ENC, items[got])); end
        got++;
      end
    end
    total++; if (got !== 3) begin bad++; $display("FAIL bp_delivered: got %0d want 3", got); end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    res_t sb[$];
    res_t exp_r, stall_r, got_r;
    logic hold, stalled;
    int sent, cyc;
    logic [DW-1:0] d;
    logic [CW-1:0] din;
    hold = 1'b0; stalled = 1'b0; sent = 0; cyc = 0; stall_r = '0;
    while ((sent < N_RAND || sb.size() != 0) && cyc < RAND_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
          bus.in_mode = 1'($urandom_range(0, 1));
          if (bus.in_mode == MODE_ENC) din = CW'($urandom);
          else begin
            d = DW'($urandom);
            din = m_encode(d);
            repeat ($urandom_range(0, 3)) din[$urandom_range(0, CW-1)] ^= 1'b1;
          end
          bus.in_data = din;
          bus.in_valid = 1'b1;
        end else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      got_r = {bus.out_mode, bus.out_data, bus.out_syndrome, bus.out_corr, bus.out_uncorr};
      total++; if (corr_cnt !== 16'(exp_corr)) begin bad++; $display("FAIL rnd_corr_cnt: got %0d want %0d", corr_cnt, exp_corr); end
      total++; if (uncorr_cnt !== 16'(exp_uncorr)) begin bad++; $display("FAIL rnd_uncorr_cnt: got %0d want %0d", uncorr_cnt, exp_uncorr); end
      if (stalled) begin
        total++; if ({bus.out_valid, got_r} !== {1'b1, stall_r}) begin bad++; $display("FAIL rnd_stall_stable: got %b/%h want 1/%h", bus.out_valid, got_r, stall_r); end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(m_expect(bus.in_mode, bus.in_data));
        sent++;
        hold = 1'b0;
      end else hold = bus.in_valid;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rnd_extra_output: got %h want none", got_r); end
        else begin
          exp_r = sb.pop_front();
          if (got_r !== exp_r) begin bad++; $display("FAIL rnd_result: got %h want %h", got_r, exp_r); end
          if (exp_r.corr && exp_corr < 65535) exp_corr++;
          if (exp_r.uncorr && exp_uncorr < 65535) exp_uncorr++;
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      if (stalled) stall_r = got_r;
    end
    total++; if (sent != N_RAND || sb.size() != 0) begin bad++; $display("FAIL rnd_timeout: got sent=%0d pending=%0d want %0d/0", sent, sb.size(), N_RAND); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_mode = MODE_DEC; bus.in_data = 22'h200017;
    @(negedge clk);
    bus.in_data = 22'h200013;
    @(negedge clk);
    bus.in_valid = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_flush%0d: got out_valid %b want 0", c, bus.out_valid); end
    end
    total++; if ({corr_cnt, uncorr_cnt} !== 32'h0) begin bad++; $display("FAIL midrst_counters: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus2.out_ready = 1'b1; bus2.in_valid = 1'b1; bus2.in_mode = MODE_DEC; bus2.in_data = 22'h200017;
      #1;
      total++; if (bus2.in_ready !== 1'b1) begin bad++; $display("FAIL sat_in_ready%0d: got %b want 1", c, bus2.in_ready); end
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (corr_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_corr_cnt: got %0d want 3", corr_cnt2); end
    total++; if (uncorr_cnt2 !== 2'd0) begin bad++; $display("FAIL sat_uncorr_cnt: got %0d want 0", uncorr_cnt2); end
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.in_mode = MODE_DEC; bus2.in_data = 22'h200017; bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if ({bus2.out_valid, bus2.out_corr} !== 2'b11) begin bad++; $display("FAIL clr_event_present: got valid/corr %b%b want 11", bus2.out_valid, bus2.out_corr); end
    total++; if (corr_cnt2 !== 2'd3) begin bad++; $display("FAIL clr_before: got %0d want 3", corr_cnt2); end
    cnt_clr2 = 1'b1;
    @(negedge clk);
    cnt_clr2 = 1'b0;
    #1;
    total++; if (corr_cnt2 !== 2'd0) begin bad++; $display("FAIL clr_priority: got %0d want 0", corr_cnt2); end
  endtask

  initial begin
    int k;
    k = 0;
    for (int p = 1; p <= NN; p++) begin
      if ((p & (p - 1)) != 0) begin
        dpos[k] = p;
        k++;
      end
    end
    rst = 1'b1;
    cnt_clr = 1'b0; cnt_clr2 = 1'b0;
    bus.in_valid = 1'b0;  bus.in_mode = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_mode = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_saturation();
    test_clear_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
